// File: rtl/add3_arb_pkg.sv
// Shared defaults, tag-width helper and operand-triple type for the add3 arbiter.
// The overflow flag is compiled in with ADD3_ARB_OVF_EN.
package add3_arb_pkg;

  localparam int N_DEF    = 16;
  localparam int NREQ_DEF = 4;

  function automatic int id_w(input int nreq);
    return ($clog2(nreq) > 1) ? $clog2(nreq) : 1;
  endfunction

  typedef struct packed {
    logic [N_DEF-1:0] a;
    logic [N_DEF-1:0] b;
    logic [N_DEF-1:0] c;
  } operand_t;

endpackage

// File: rtl/add3_core.sv
// Registered three-input unsigned adder with load enable.
// Overflow output exists only when ADD3_ARB_OVF_EN is defined.
module add3_core
  import add3_arb_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
`ifdef ADD3_ARB_OVF_EN
  output logic         ovf,
`endif
  output logic [N-1:0] sum
);

`ifdef ADD3_ARB_OVF_EN
  // Two guard bits hold the worst case 3*(2^N-1).
  logic [N+1:0] wide;

  assign wide = {2'b00, a} + {2'b00, b} + {2'b00, c};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      sum <= wide[N-1:0];
      ovf <= |wide[N+1:N];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (load) begin
      sum <= a + b + c;
    end
  end
`endif

endmodule

// File: rtl/add3_arbiter.sv
// Round-robin arbiter sharing one registered three-operand adder among NREQ requesters.
// Optional res_ovf port is enabled by ADD3_ARB_OVF_EN.
module add3_arbiter
  import add3_arb_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int NREQ = NREQ_DEF,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*N-1:0] req_c,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [N-1:0]      res_data,
  output logic [ID_W-1:0]   res_id,
`ifdef ADD3_ARB_OVF_EN
  output logic              res_ovf,
`endif
  input  logic              res_ready
);

  logic [ID_W-1:0] last;
  logic [ID_W-1:0] grant_id;
  logic [NREQ-1:0] grant;
  logic            found;
  logic            stall;
  logic            handshake;
  int              idx;

  assign stall = res_valid & ~res_ready;

  // Scan starts just past the last winner so every requester gets its turn.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    if (!stall) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(last) + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_id   = ID_W'(idx);
        end
      end
    end
  end

  assign req_ready = grant;
  assign handshake = found;

  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= ID_W'(NREQ - 1);
      res_valid <= 1'b0;
      res_id    <= '0;
    end else begin
      if (handshake) begin
        last   <= grant_id;
        res_id <= grant_id;
      end
      if (!stall) begin
        res_valid <= handshake;
      end
    end
  end

  add3_core #(.N(N)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (handshake),
    .a    (req_a[int'(grant_id)*N +: N]),
    .b    (req_b[int'(grant_id)*N +: N]),
    .c    (req_c[int'(grant_id)*N +: N]),
`ifdef ADD3_ARB_OVF_EN
    .ovf  (res_ovf),
`endif
    .sum  (res_data)
  );

endmodule
